// File: rtl/kb_pkg.sv
// Shared definitions for the PS/2 keyboard event decoder.
// Contents: decoder FSM state enum, prefix/modifier scancodes, pause skip length,
//           and a helper that recognises line-status bytes that carry no key data.
package kb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK,
    PAUSE
  } kb_state_t;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_E1     = 8'hE1;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  // Bytes following E1 in the Pause key sequence (E1 14 77 E1 F0 14 F0 77).
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  // Controller/keyboard status bytes (ack, BAT, echo, resend, errors).
  function automatic logic is_ignored(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
  endfunction

endpackage

// File: rtl/kb_timeout.sv
// Saturating idle-cycle counter used to abandon stale scancode prefixes.
// Ports: clk, reset (sync, active-high), clear (restart count), enable (count
//        this cycle), expired (count has reached TIMEOUT and is holding there).
module kb_timeout #(
  parameter int TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

  logic [W-1:0] count;

  // Saturates at LIMIT so a long idle stretch can never wrap back to zero.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/kb_event_decoder.sv
// PS/2 set-2 byte stream to key-make events, with shift and caps-lock tracking.
// Ports: i_clk, i_reset (sync, active-high), i_byte/i_valid in; o_scancode,
//        o_extended, o_valid (1-cycle pulse, 1 cycle after last byte), o_shift, o_capslock.
// Optional: define KB_REPEAT_SUPPRESS_EN to drop typematic repeats of the last make.
module kb_event_decoder
  import kb_pkg::*;
#(
  parameter int PREFIX_TIMEOUT = 1000000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_byte,
  input  logic       i_valid,
  output logic [7:0] o_scancode,
  output logic       o_extended,
  output logic       o_shift,
  output logic       o_capslock,
  output logic       o_valid
);

  kb_state_t  state, next_state;
  logic [2:0] skip_cnt;
  logic       lshift, rshift, caps_held;
  logic       expired;

  logic       byte_ign, key_ext, is_make, is_break, emit_cand, emit;
  logic       is_mod, is_fake;

  kb_timeout #(.TIMEOUT(PREFIX_TIMEOUT)) u_timeout (
    .clk    (i_clk),
    .reset  (i_reset),
    .clear  (i_valid || (state == IDLE)),
    .enable (state != IDLE),
    .expired(expired)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state logic; a byte always takes priority over a coincident expiry.
  always_comb begin
    next_state = state;
    byte_ign   = is_ignored(i_byte);
    if (i_valid) begin
      case (state)
        IDLE: begin
          if (byte_ign)              next_state = IDLE;
          else if (i_byte == SC_E0)  next_state = EXT;
          else if (i_byte == SC_F0)  next_state = BRK;
          else if (i_byte == SC_E1)  next_state = PAUSE;
          else                       next_state = IDLE;
        end
        EXT:     next_state = (!byte_ign && i_byte == SC_F0) ? EXT_BRK : IDLE;
        BRK:     next_state = IDLE;
        EXT_BRK: next_state = IDLE;
        PAUSE:   next_state = (skip_cnt == 3'd1) ? IDLE : PAUSE;
        default: next_state = IDLE;
      endcase
    end else if (expired) begin
      next_state = IDLE;
    end
  end

  // Event decode for the byte presented this cycle.
  always_comb begin
    key_ext  = (state == EXT) || (state == EXT_BRK);
    is_make  = i_valid && !byte_ign &&
               (((state == IDLE) && !(i_byte inside {SC_E0, SC_F0, SC_E1})) ||
                ((state == EXT)  && (i_byte != SC_F0)));
    is_break = i_valid && !byte_ign && ((state == BRK) || (state == EXT_BRK));
    is_mod   = !key_ext && (i_byte inside {SC_LSHIFT, SC_RSHIFT, SC_CAPS});
    // E0 12 / E0 59 are synthetic shifts some keyboards wrap around nav keys.
    is_fake  = key_ext && (i_byte inside {SC_LSHIFT, SC_RSHIFT});
    emit_cand = is_make && !is_mod && !is_fake;
  end

`ifdef KB_REPEAT_SUPPRESS_EN
  logic       last_have;
  logic [7:0] last_code;
  logic       last_ext;
  logic       last_match;

  assign last_match = last_have && (last_code == i_byte) && (last_ext == key_ext);
  assign emit       = emit_cand && !last_match;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      last_have <= 1'b0;
      last_code <= 8'h00;
      last_ext  <= 1'b0;
    end else if (emit) begin
      last_have <= 1'b1;
      last_code <= i_byte;
      last_ext  <= key_ext;
    end else if (is_break && last_match) begin
      last_have <= 1'b0;
    end
  end
`else
  assign emit = emit_cand;
`endif

  // Skip counter only lives while in PAUSE; loaded on entry, cleared on any exit.
  always_ff @(posedge i_clk) begin
    if (i_reset)                  skip_cnt <= 3'd0;
    else if (next_state != PAUSE) skip_cnt <= 3'd0;
    else if (state != PAUSE)      skip_cnt <= PAUSE_SKIP;
    else if (i_valid)             skip_cnt <= skip_cnt - 3'd1;
  end

  // Registered outputs and modifier state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid    <= 1'b0;
      o_scancode <= 8'h00;
      o_extended <= 1'b0;
      o_capslock <= 1'b0;
      lshift     <= 1'b0;
      rshift     <= 1'b0;
      caps_held  <= 1'b0;
    end else begin
      o_valid <= emit;
      if (emit) begin
        o_scancode <= i_byte;
        o_extended <= key_ext;
      end
      if (is_make && !key_ext) begin
        case (i_byte)
          SC_LSHIFT: lshift <= 1'b1;
          SC_RSHIFT: rshift <= 1'b1;
          SC_CAPS: begin
            // Held flag stops typematic repeats from toggling again.
            if (!caps_held) o_capslock <= ~o_capslock;
            caps_held <= 1'b1;
          end
          default: ;
        endcase
      end
      if (is_break && !key_ext) begin
        case (i_byte)
          SC_LSHIFT: lshift    <= 1'b0;
          SC_RSHIFT: rshift    <= 1'b0;
          SC_CAPS:   caps_held <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign o_shift = lshift | rshift;

endmodule

// File: tb/tb_kb_event_decoder.sv
module tb_kb_event_decoder;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] byte_in;
  logic       vld_in;
  logic [7:0] scancode;
  logic       extended, shift, capslock, vld_out;

  always #5 clk = ~clk;

  kb_event_decoder #(.PREFIX_TIMEOUT(T)) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_byte    (byte_in),
    .i_valid   (vld_in),
    .o_scancode(scancode),
    .o_extended(extended),
    .o_shift   (shift),
    .o_capslock(capslock),
    .o_valid   (vld_out)
  );

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Reference model: protocol-level view of the keyboard stream.
  bit         m_ext, m_brk;
  int         m_skip;
  bit         m_ls, m_rs, m_caps, m_caps_held;
  bit         m_val, m_ex;
  logic [7:0] m_sc;
  bit         m_last_have, m_last_ext;
  logic [7:0] m_last_code;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_ext = 0; m_brk = 0; m_skip = 0;
    m_ls = 0; m_rs = 0; m_caps = 0; m_caps_held = 0;
    m_val = 0; m_ex = 0; m_sc = 8'h00;
    m_last_have = 0; m_last_ext = 0; m_last_code = 8'h00;
  endtask

  task automatic m_make(input logic [7:0] b, input bit e);
    if (!e && b == 8'h12) m_ls = 1;
    else if (!e && b == 8'h59) m_rs = 1;
    else if (!e && b == 8'h58) begin
      if (!m_caps_held) m_caps = !m_caps;
      m_caps_held = 1;
    end else if (e && (b == 8'h12 || b == 8'h59)) begin
      m_val = 0;
    end else begin
`ifdef KB_REPEAT_SUPPRESS_EN
      if (m_last_have && m_last_code == b && m_last_ext == e) return;
      m_last_have = 1; m_last_code = b; m_last_ext = e;
`endif
      m_val = 1; m_sc = b; m_ex = e;
    end
  endtask

  task automatic m_break(input logic [7:0] b, input bit e);
    if (!e) begin
      if (b == 8'h12) m_ls = 0;
      if (b == 8'h59) m_rs = 0;
      if (b == 8'h58) m_caps_held = 0;
    end
`ifdef KB_REPEAT_SUPPRESS_EN
    if (m_last_have && m_last_code == b && m_last_ext == e) m_last_have = 0;
`endif
  endtask

  // idle = number of clock edges without a byte since the previous byte.
  task automatic m_step(input logic [7:0] b, input int idle);
    m_val = 0;
    if ((m_ext || m_brk || m_skip > 0) && idle > T) begin
      m_ext = 0; m_brk = 0; m_skip = 0;
    end
    if (m_skip > 0) begin
      m_skip--;
      return;
    end
    if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) begin
      m_ext = 0; m_brk = 0;
      return;
    end
    if (m_brk) begin
      m_break(b, m_ext);
      m_ext = 0; m_brk = 0;
    end else if (m_ext) begin
      if (b == 8'hF0) m_brk = 1;
      else begin
        m_make(b, 1);
        m_ext = 0;
      end
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE1) m_skip = 7;
    else m_make(b, 0);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"},    {7'd0, vld_out},  {7'd0, m_val});
    chk({tag, ".scancode"}, scancode,         m_sc);
    chk({tag, ".extended"}, {7'd0, extended}, {7'd0, m_ex});
    chk({tag, ".shift"},    {7'd0, shift},    {7'd0, m_ls | m_rs});
    chk({tag, ".caps"},     {7'd0, capslock}, {7'd0, m_caps});
  endtask

  // Waits gap extra cycles, strobes one byte, then checks the registered result.
  task automatic send(input logic [7:0] b, input int gap, input string tag);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    byte_in = b;
    vld_in  = 1'b1;
    m_step(b, gap + 1);
    @(negedge clk);
    vld_in = 1'b0;
    if (vld_out) pulses++;
    check_outputs(tag);
  endtask

  task automatic do_reset(input bit with_byte);
    @(negedge clk);
    rst     = 1'b1;
    vld_in  = with_byte;
    byte_in = 8'h1C;
    @(negedge clk);
    rst    = 1'b0;
    vld_in = 1'b0;
    m_reset();
    check_outputs("reset");
  endtask

  logic [7:0] pool [16];

  initial begin
    rst = 1'b1; byte_in = 8'h00; vld_in = 1'b0;
    m_reset();
    pool = '{8'h1C, 8'h1B, 8'h23, 8'h75, 8'h12, 8'h59, 8'h58, 8'hE0,
             8'hF0, 8'hF0, 8'hE1, 8'hAA, 8'h00, 8'hFA, 8'h6B, 8'h1C};
    repeat (2) @(negedge clk);

    // Reset wins over a coincident byte.
    do_reset(1'b1);
    chk("reset.o_valid_const", {7'd0, vld_out}, 8'h00);

    // Plain make then break.
    pulses = 0;
    send(8'h1C, 0, "mk1C");
    chk("mk1C.code_const", scancode, 8'h1C);
    send(8'hF0, 0, "brk_pre");
    send(8'h1C, 0, "brk1C");
    chk("mkbrk.pulses", 8'(pulses), 8'd1);

    // Shift held around a make.
    pulses = 0;
    send(8'h12, 0, "lshift");
    chk("lshift.shift_const", {7'd0, shift}, 8'h01);
    send(8'h1C, 0, "shift1C");
    send(8'hF0, 0, "s_pre1"); send(8'h1C, 0, "s_brk1C");
    send(8'hF0, 0, "s_pre2"); send(8'h12, 0, "s_brk12");
    chk("shift.released", {7'd0, shift}, 8'h00);
    chk("shift.pulses", 8'(pulses), 8'd1);

    // Caps lock toggle with typematic repeat.
    pulses = 0;
    send(8'h58, 0, "caps1");
    chk("caps.on", {7'd0, capslock}, 8'h01);
    send(8'h58, 0, "caps_rep");
    send(8'hF0, 0, "c_pre1"); send(8'h58, 0, "c_brk1");
    send(8'h58, 0, "caps2");
    chk("caps.off", {7'd0, capslock}, 8'h00);
    send(8'hF0, 0, "c_pre2"); send(8'h58, 0, "c_brk2");
    chk("caps.pulses", 8'(pulses), 8'd0);

    // Extended make and fake shift.
    send(8'hE0, 0, "e_pre1"); send(8'h75, 0, "ext75");
    chk("ext75.ext_const", {7'd0, extended}, 8'h01);
    send(8'hE0, 0, "e_pre2"); send(8'h12, 0, "fake12");
    chk("fake12.shift_const", {7'd0, shift}, 8'h00);

    // Prefix timeout: just inside the window keeps the prefix, long idle drops it.
    send(8'hE0, 0, "t_pre1"); send(8'h6B, T - 2, "t_inside");
    send(8'hE0, 0, "t_pre2"); send(8'h1C, T + 2, "t_expired");
    chk("t_expired.ext_const", {7'd0, extended}, 8'h00);

    // Pause sequence is swallowed.
    pulses = 0;
    send(8'hE1, 0, "p0"); send(8'h14, 0, "p1"); send(8'h77, 0, "p2");
    send(8'hE1, 0, "p3"); send(8'hF0, 0, "p4"); send(8'h14, 0, "p5");
    send(8'hF0, 0, "p6"); send(8'h77, 0, "p7");
    send(8'h1C, 0, "p_after");
    chk("pause.pulses", 8'(pulses), 8'd1);

    // Typematic repeats after a release.
    send(8'hF0, 0, "r_pre"); send(8'h1C, 0, "r_brk");
    pulses = 0;
    send(8'h1C, 0, "rep1"); send(8'h1C, 0, "rep2"); send(8'h1C, 1, "rep3");
`ifdef KB_REPEAT_SUPPRESS_EN
    chk("repeat.pulses", 8'(pulses), 8'd1);
`else
    chk("repeat.pulses", 8'(pulses), 8'd3);
`endif

    // Reset mid-prefix with modifiers set.
    send(8'h58, 0, "pre_rst_caps"); send(8'hE0, 0, "pre_rst_e0");
    do_reset(1'b0);
    send(8'h75, 0, "post_rst75");
    chk("post_rst.ext_const", {7'd0, extended}, 8'h00);

    // Random stream against the model.
    for (int i = 0; i < 300; i++) begin
      int gap;
      gap = ($urandom_range(0, 9) == 0) ? (T + 2 + int'($urandom_range(0, 4)))
                                        : int'($urandom_range(0, 3));
      send(pool[$urandom_range(0, 15)], gap, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kb_event_decoder.md
KB_EVENT_DECODER -- requirements
Module: kb_event_decoder

Interface
REQ-001 SHALL have parameter PREFIX_TIMEOUT, default 1000000, meaning the clock cycles allowed between prefix bytes before an incomplete sequence is abandoned.
REQ-002 SHALL have port i_clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port i_reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port i_byte, input, 8, a received PS/2 byte from the line receiver.
REQ-005 SHALL have port i_valid, input, 1, a one-cycle strobe qualifying i_byte.
REQ-006 SHALL have port o_scancode, output, 8, the make code of the last emitted key event.
REQ-007 SHALL have port o_extended, output, 1, set when the emitted event carried an E0 prefix.
REQ-008 SHALL have port o_shift, output, 1, set when left or right shift is currently held.
REQ-009 SHALL have port o_capslock, output, 1, the caps-lock toggle state.
REQ-010 SHALL have port o_valid, output, 1, a one-cycle pulse when o_scancode/o_extended carry a new make event.

Function
REQ-011 SHALL use FSM states IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0) and PAUSE (skipping E1 sequence).
REQ-012 SHALL handle bytes in IDLE as follows: E0 -> EXT; F0 -> BRK; E1 -> PAUSE with skip count 7; any other byte is a make code and the FSM stays in IDLE.
REQ-013 SHALL handle bytes in EXT as follows: F0 -> EXT_BRK; any other byte is an extended make and the FSM returns to IDLE.
REQ-014 SHALL return BRK and EXT_BRK to IDLE on the next byte, treating that byte as a break code; a break never pulses o_valid.
REQ-015 SHALL, in PAUSE, decrement the skip count on each i_valid, return to IDLE after the 7th byte, and emit no events and update no modifiers.
REQ-016 SHALL treat make 12/59 (non-extended) as setting the left/right shift held flag and break 12/59 as clearing it; o_shift = left OR right.
REQ-017 SHALL ignore extended 12 (fake shift) and extended 59 entirely.
REQ-018 SHALL toggle o_capslock on a non-extended make of 58 only when caps is not already held; break 58 clears the held flag, so typematic repeats do not re-toggle.
REQ-019 SHALL NOT pulse o_valid for shift or caps-lock makes.
REQ-020 SHALL silently drop the bytes 00, AA, EE, FA, FE and FF in any state except PAUSE, with the FSM returning to IDLE.
REQ-021 SHALL pulse o_valid for every other make, with latency of exactly one cycle after the i_valid of the final byte; o_scancode/o_extended SHALL hold until the next event.
REQ-022 SHALL update o_shift/o_capslock in the same cycle as an o_valid caused by the same byte, reflecting state before that byte.
REQ-023 SHALL count cycles without i_valid in EXT, BRK, EXT_BRK or PAUSE; on reaching PREFIX_TIMEOUT it SHALL return to IDLE with no event.
REQ-024 SHALL give i_valid priority when it coincides with timeout expiry: the byte is processed and the timeout is ignored.
REQ-025 SHALL size the timeout counter as $clog2(PREFIX_TIMEOUT+1) bits, SHALL clear it on every i_valid, and it SHALL never wrap.

Reset
REQ-026 SHALL set, on i_reset, state=IDLE, o_scancode=00, o_extended=0, o_shift=0, o_capslock=0, o_valid=0, all held flags clear, and counters zero.
REQ-027 SHALL let reset win over a coincident i_valid and abandon any partial sequence.

Configuration
REQ-028 SHALL, when KB_REPEAT_SUPPRESS_EN is defined, track the last emitted make (code plus extended bit) and suppress o_valid for an identical make until that key's break is seen or a different make is emitted.
REQ-029 SHALL, when KB_REPEAT_SUPPRESS_EN is not defined, pulse o_valid for every typematic repeat make.

Structure
REQ-030 SHALL place the FSM state enum and scancode constants (E0, F0, E1, 12, 59, 58, ignored bytes) in shared package kb_pkg.
REQ-031 SHALL implement the prefix timeout counter as sub-module kb_timeout (inputs clear and enable; output expired).

Verification
REQ-032 SHALL cover: bytes 1C, F0, 1C -> one o_valid with o_scancode=1C, o_extended=0, o_shift=0.
REQ-033 SHALL cover: 12, 1C, F0 1C, F0 12 -> a single o_valid for 1C with o_shift=1; o_shift=0 after F0 12.
REQ-034 SHALL cover: 58, 58, F0 58, 58, F0 58 -> o_capslock 0->1 (repeat ignored) ->0; no o_valid.
REQ-035 SHALL cover: E0 75 -> o_valid with o_scancode=75, o_extended=1; E0 12 -> no shift change.
REQ-036 SHALL cover: E0, then idle for PREFIX_TIMEOUT cycles, then 1C -> o_valid with 1C, o_extended=0.
REQ-037 SHALL cover: E1 14 77 E1 F0 14 F0 77, then 1C -> only the 1C event is emitted; with KB_REPEAT_SUPPRESS_EN, 1C 1C 1C -> one o_valid.
